// File: rtl/axil_arb_pkg.sv
// Shared types and constants for the two-master AXI4-lite arbiter.
package axil_arb_pkg;
  localparam int N_MST = 2;

  typedef logic mst_idx_t;

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP} state_e;
endpackage

// File: rtl/axil_arb_pick.sv
// Combinational grant select for two masters; AXIL_ARB_RR_EN selects round-robin,
// otherwise fixed priority with M1 (data) winning a tie.
module axil_arb_pick
  import axil_arb_pkg::*;
(
  input  logic [N_MST-1:0] req,
`ifdef AXIL_ARB_RR_EN
  input  mst_idx_t         last,
`endif
  output mst_idx_t         g,
  output logic             any
);

  always_comb begin
    any = |req;
`ifdef AXIL_ARB_RR_EN
    g = (&req) ? ~last : req[1];
`else
    g = req[1];
`endif
  end

endmodule

// File: rtl/axil_arbiter_2to1.sv
// Two AXI4-lite masters share one slave, one read (AR+R) or write (AW+W+B) per grant.
// Grant is registered in IDLE, so each transaction pays one idle cycle. Macro: AXIL_ARB_RR_EN.
module axil_arbiter_2to1
  import axil_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [N_MST-1:0]                  m_arvalid,
  output logic [N_MST-1:0]                  m_arready,
  input  logic [N_MST-1:0][ADDR_W-1:0]      m_araddr,
  input  logic [N_MST-1:0][2:0]             m_arprot,
  output logic [N_MST-1:0]                  m_rvalid,
  input  logic [N_MST-1:0]                  m_rready,
  output logic [DATA_W-1:0]                 m_rdata,
  input  logic [N_MST-1:0]                  m_awvalid,
  output logic [N_MST-1:0]                  m_awready,
  input  logic [N_MST-1:0][ADDR_W-1:0]      m_awaddr,
  input  logic [N_MST-1:0][2:0]             m_awprot,
  input  logic [N_MST-1:0]                  m_wvalid,
  output logic [N_MST-1:0]                  m_wready,
  input  logic [N_MST-1:0][DATA_W-1:0]      m_wdata,
  input  logic [N_MST-1:0][DATA_W/8-1:0]    m_wstrb,
  output logic [N_MST-1:0]                  m_bvalid,
  input  logic [N_MST-1:0]                  m_bready,
  output logic                              s_arvalid,
  input  logic                              s_arready,
  output logic [ADDR_W-1:0]                 s_araddr,
  output logic [2:0]                        s_arprot,
  input  logic                              s_rvalid,
  output logic                              s_rready,
  input  logic [DATA_W-1:0]                 s_rdata,
  output logic                              s_awvalid,
  input  logic                              s_awready,
  output logic [ADDR_W-1:0]                 s_awaddr,
  output logic [2:0]                        s_awprot,
  output logic                              s_wvalid,
  input  logic                              s_wready,
  output logic [DATA_W-1:0]                 s_wdata,
  output logic [DATA_W/8-1:0]               s_wstrb,
  input  logic                              s_bvalid,
  output logic                              s_bready
);

  state_e     state, state_nxt;
  mst_idx_t   g, g_nxt;
  logic       aw_done, aw_done_nxt;
  logic       w_done, w_done_nxt;
  mst_idx_t   pick_g;
  logic       pick_any;
  logic [N_MST-1:0] rd_req, wr_req;
  logic       ar_hs, r_hs, aw_hs, w_hs, b_hs, aw_fin, w_fin;

  assign rd_req = m_arvalid;
  assign wr_req = m_awvalid | m_wvalid;

`ifdef AXIL_ARB_RR_EN
  mst_idx_t last, last_nxt;

  axil_arb_pick u_pick (
    .req  (rd_req | wr_req),
    .last (last),
    .g    (pick_g),
    .any  (pick_any)
  );
`else
  axil_arb_pick u_pick (
    .req  (rd_req | wr_req),
    .g    (pick_g),
    .any  (pick_any)
  );
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      g       <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
`ifdef AXIL_ARB_RR_EN
      last    <= 1'b1;
`endif
    end else begin
      state   <= state_nxt;
      g       <= g_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
`ifdef AXIL_ARB_RR_EN
      last    <= last_nxt;
`endif
    end
  end

  assign ar_hs  = s_arvalid & s_arready;
  assign r_hs   = s_rvalid & s_rready;
  assign aw_hs  = s_awvalid & s_awready;
  assign w_hs   = s_wvalid & s_wready;
  assign b_hs   = s_bvalid & s_bready;
  assign aw_fin = aw_done | aw_hs;
  assign w_fin  = w_done | w_hs;

  always_comb begin
    state_nxt   = state;
    g_nxt       = g;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
`ifdef AXIL_ARB_RR_EN
    last_nxt    = last;
`endif
    case (state)
      IDLE: begin
        if (pick_any) begin
          g_nxt     = pick_g;
`ifdef AXIL_ARB_RR_EN
          last_nxt  = pick_g;
`endif
          state_nxt = rd_req[pick_g] ? RD_ADDR : WR;
        end
      end
      RD_ADDR: if (ar_hs) state_nxt = RD_DATA;
      RD_DATA: if (r_hs) state_nxt = IDLE;
      WR: begin
        if (aw_fin && w_fin) begin
          state_nxt   = WR_RESP;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
        end else begin
          aw_done_nxt = aw_fin;
          w_done_nxt  = w_fin;
        end
      end
      WR_RESP: if (b_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Payloads follow the grant unconditionally; only valids and readies are state-gated.
  always_comb begin
    m_arready = '0;
    m_rvalid  = '0;
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    m_rdata   = s_rdata;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    s_araddr  = m_araddr[g];
    s_arprot  = m_arprot[g];
    s_awaddr  = m_awaddr[g];
    s_awprot  = m_awprot[g];
    s_wdata   = m_wdata[g];
    s_wstrb   = m_wstrb[g];
    case (state)
      RD_ADDR: begin
        s_arvalid    = m_arvalid[g];
        m_arready[g] = s_arready;
      end
      RD_DATA: begin
        m_rvalid[g] = s_rvalid;
        s_rready    = m_rready[g];
      end
      WR: begin
        s_awvalid    = m_awvalid[g] & ~aw_done;
        m_awready[g] = s_awready & ~aw_done;
        s_wvalid     = m_wvalid[g] & ~w_done;
        m_wready[g]  = s_wready & ~w_done;
      end
      WR_RESP: begin
        m_bvalid[g] = s_bvalid;
        s_bready    = m_bready[g];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axil_arbiter_2to1.sv
// Bench for axil_arbiter_2to1: bus-functional masters and slave in one driver process,
// expected responses queued at issue time and popped by an independent monitor.
module tb_axil_arbiter_2to1;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          lag;
  } wcmd_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]         m_arvalid, m_arready, m_rvalid, m_rready;
  logic [1:0][AW-1:0] m_araddr, m_awaddr;
  logic [1:0][2:0]    m_arprot, m_awprot;
  logic [DW-1:0]      m_rdata;
  logic [1:0]         m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [1:0][DW-1:0] m_wdata;
  logic [1:0][3:0]    m_wstrb;
  logic               s_arvalid, s_arready, s_rvalid, s_rready;
  logic [AW-1:0]      s_araddr, s_awaddr;
  logic [2:0]         s_arprot, s_awprot;
  logic [DW-1:0]      s_rdata, s_wdata;
  logic               s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [3:0]         s_wstrb;

  axil_arbiter_2to1 #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  int          n_chk = 0, n_pass = 0;
  bit          rnd_mode = 1'b0;
  int          s_rdelay = 0;
  logic [31:0] rd_cmd_q [2][$];
  wcmd_t       wr_cmd_q [2][$];
  logic [31:0] rd_exp_q [2][$];
  int          wr_exp [2] = '{0, 0};
  int          r_cnt [2] = '{0, 0};
  int          ev_log [$];
  int          s_aw_n = 0, s_w_n = 0;
  logic [31:0] cap_awaddr, cap_wdata;
  logic [3:0]  cap_wstrb;

  // driver-private state
  bit          rd_act [2], wr_act [2], aw_hold [2], w_sent [2];
  int          aw_cnt [2];
  bit          h_ar [2], h_r [2], h_aw [2], h_w [2], h_b [2];
  bit          h_sar, h_sr, h_saw, h_sw, h_sb;
  logic [31:0] a_sar, a_saw, d_sw;
  logic [3:0]  st_sw;
  bit          rd_pend, aw_got, w_got, b_arm;
  int          rd_cnt, b_cnt;
  logic [31:0] rd_dat;

  function automatic logic [31:0] slv_rdata(input logic [31:0] a);
    case (a)
      32'h100: return 32'hDEADBEEF;
      32'h104: return 32'hCAFEF00D;
      32'h300: return 32'h0BADF00D;
      default: return a ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  function automatic logic [14:0] outs();
    return {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready,
            m_arready, m_rvalid, m_awready, m_wready, m_bvalid};
  endfunction

  function automatic string log_str();
    string s = "";
    foreach (ev_log[k]) begin
      if (k != 0) s = {s, ","};
      s = {s, $sformatf("%0d", ev_log[k])};
    end
    return s;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic chk_str(input string name, input string got, input string exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %s expected %s", name, got, exp);
  endtask

  task automatic issue_rd(input int i, input logic [31:0] a, input logic [31:0] e, input bit has_exp);
    rd_cmd_q[i].push_back(a);
    if (has_exp) rd_exp_q[i].push_back(e);
  endtask

  task automatic issue_wr(input int i, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int lag);
    wcmd_t c;
    c.addr = a; c.data = d; c.strb = s; c.lag = lag;
    wr_cmd_q[i].push_back(c);
    wr_exp[i]++;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    bit done = 1'b0;
    for (int k = 0; k < max_cyc && !done; k++) begin
      @(negedge clk);
      done = rd_cmd_q[0].size() == 0 && rd_cmd_q[1].size() == 0 &&
             wr_cmd_q[0].size() == 0 && wr_cmd_q[1].size() == 0 &&
             rd_exp_q[0].size() == 0 && rd_exp_q[1].size() == 0 &&
             wr_exp[0] == 0 && wr_exp[1] == 0;
    end
    chk({name, "_drained"}, done, 1);
    repeat (2) @(negedge clk);
  endtask

  // Request must appear with the slave idle, then reach the slave exactly one cycle later.
  task automatic check_ar_grant(input string name, input int i, input logic [31:0] a);
    int k = 0;
    while (!m_arvalid[i] && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_req_seen"}, m_arvalid[i], 1);
    chk({name, "_s_arvalid_idle"}, s_arvalid, 0);
    @(negedge clk);
    chk({name, "_s_arvalid"}, s_arvalid, 1);
    chk({name, "_s_araddr"}, s_araddr, a);
    chk({name, "_s_arprot"}, s_arprot, (i == 1) ? 3'b001 : 3'b100);
    chk({name, "_m_arready"}, m_arready, (i == 1) ? {s_arready, 1'b0} : {1'b0, s_arready});
  endtask

  // Bus-functional masters and slave; sample at negedge, drive just after posedge.
  initial begin : drv
    wcmd_t c;
    m_arvalid = '0; m_araddr = '0; m_arprot = '0; m_rready = '1;
    m_awvalid = '0; m_awaddr = '0; m_awprot = '0; m_wvalid = '0; m_wdata = '0; m_wstrb = '0;
    m_bready = '1;
    s_arready = 1'b1; s_rvalid = 1'b0; s_rdata = '0;
    s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        h_ar[i] = m_arvalid[i] & m_arready[i];
        h_r[i]  = m_rvalid[i] & m_rready[i];
        h_aw[i] = m_awvalid[i] & m_awready[i];
        h_w[i]  = m_wvalid[i] & m_wready[i];
        h_b[i]  = m_bvalid[i] & m_bready[i];
      end
      h_sar = s_arvalid & s_arready; a_sar = s_araddr;
      h_sr  = s_rvalid & s_rready;
      h_saw = s_awvalid & s_awready; a_saw = s_awaddr;
      h_sw  = s_wvalid & s_wready; d_sw = s_wdata; st_sw = s_wstrb;
      h_sb  = s_bvalid & s_bready;
      @(posedge clk);
      #1;
      if (reset) begin
        m_arvalid = '0; m_awvalid = '0; m_wvalid = '0;
        s_rvalid = 1'b0; s_bvalid = 1'b0;
        rd_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0; b_arm = 1'b0;
        for (int i = 0; i < 2; i++) begin
          rd_act[i] = 1'b0; wr_act[i] = 1'b0; aw_hold[i] = 1'b0; w_sent[i] = 1'b0;
        end
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (h_ar[i]) m_arvalid[i] = 1'b0;
          if (h_r[i]) rd_act[i] = 1'b0;
          if (!rd_act[i] && rd_cmd_q[i].size() > 0) begin
            m_araddr[i]  = rd_cmd_q[i].pop_front();
            m_arprot[i]  = (i == 1) ? 3'b001 : 3'b100;
            m_arvalid[i] = 1'b1;
            rd_act[i]    = 1'b1;
          end
          if (h_aw[i]) m_awvalid[i] = 1'b0;
          if (h_w[i]) begin
            m_wvalid[i] = 1'b0;
            w_sent[i]   = 1'b1;
          end
          if (aw_hold[i] && w_sent[i]) begin
            if (aw_cnt[i] > 0) aw_cnt[i]--;
            if (aw_cnt[i] == 0) begin
              m_awvalid[i] = 1'b1;
              aw_hold[i]   = 1'b0;
            end
          end
          if (h_b[i]) wr_act[i] = 1'b0;
          if (!wr_act[i] && wr_cmd_q[i].size() > 0) begin
            c = wr_cmd_q[i].pop_front();
            m_awaddr[i] = c.addr; m_awprot[i] = 3'b010;
            m_wdata[i]  = c.data; m_wstrb[i]  = c.strb;
            wr_act[i] = 1'b1; w_sent[i] = 1'b0; m_wvalid[i] = 1'b1;
            if (c.lag == 0) m_awvalid[i] = 1'b1;
            else begin
              aw_hold[i] = 1'b1;
              aw_cnt[i]  = c.lag;
            end
          end
          m_rready[i] = rnd_mode ? ($urandom % 4 != 0) : 1'b1;
          m_bready[i] = rnd_mode ? ($urandom % 4 != 0) : 1'b1;
        end
        if (h_sr) begin
          s_rvalid = 1'b0;
          rd_pend  = 1'b0;
        end
        if (h_sar) begin
          rd_pend = 1'b1;
          rd_cnt  = rnd_mode ? int'($urandom % 3) : s_rdelay;
          rd_dat  = slv_rdata(a_sar);
        end
        if (rd_pend && !s_rvalid) begin
          if (rd_cnt > 0) rd_cnt--;
          else begin
            s_rvalid = 1'b1;
            s_rdata  = rd_dat;
          end
        end
        if (h_sb) begin
          s_bvalid = 1'b0; aw_got = 1'b0; w_got = 1'b0; b_arm = 1'b0;
        end
        if (h_saw) begin
          aw_got = 1'b1; cap_awaddr = a_saw; s_aw_n++;
        end
        if (h_sw) begin
          w_got = 1'b1; cap_wdata = d_sw; cap_wstrb = st_sw; s_w_n++;
        end
        if (aw_got && w_got && !b_arm) begin
          b_arm = 1'b1;
          b_cnt = rnd_mode ? int'($urandom % 3) : 0;
        end
        if (b_arm && !s_bvalid) begin
          if (b_cnt > 0) b_cnt--;
          else s_bvalid = 1'b1;
        end
        s_arready = rnd_mode ? $urandom_range(1, 0) : 1'b1;
        s_awready = rnd_mode ? $urandom_range(1, 0) : 1'b1;
        s_wready  = rnd_mode ? $urandom_range(1, 0) : 1'b1;
      end
    end
  end

  // Monitor: scoreboard pops and protocol checks.
  initial begin : mon
    bit          p_ar = 1'b0, p_aw = 1'b0, p_w = 1'b0;
    logic [31:0] p_araddr, p_awaddr, p_wdata, e;
    forever begin
      @(negedge clk);
      if (reset) begin
        p_ar = 1'b0; p_aw = 1'b0; p_w = 1'b0;
      end else begin
        if (s_arvalid && s_arready) ev_log.push_back(40);
        if (s_awvalid && s_awready) ev_log.push_back(30);
        if (s_wvalid && s_wready)   ev_log.push_back(31);
        if (p_ar) chk("ar_valid_hold", {s_arvalid, s_araddr}, {1'b1, p_araddr});
        if (p_aw) chk("aw_valid_hold", {s_awvalid, s_awaddr}, {1'b1, p_awaddr});
        if (p_w)  chk("w_valid_hold", {s_wvalid, s_wdata}, {1'b1, p_wdata});
        p_ar = s_arvalid & ~s_arready; p_araddr = s_araddr;
        p_aw = s_awvalid & ~s_awready; p_awaddr = s_awaddr;
        p_w  = s_wvalid & ~s_wready;   p_wdata  = s_wdata;
        if (s_arvalid) chk("one_outstanding", s_awvalid | s_wvalid, 0);
        if (m_rvalid != 2'b00) chk("rvalid_onehot", $onehot(m_rvalid), 1);
        if (m_bvalid != 2'b00) chk("bvalid_onehot", $onehot(m_bvalid), 1);
        for (int i = 0; i < 2; i++) begin
          if (m_rvalid[i] && m_rready[i]) begin
            ev_log.push_back(10 + i);
            r_cnt[i]++;
            chk($sformatf("r_expected_m%0d", i), rd_exp_q[i].size() > 0, 1);
            if (rd_exp_q[i].size() > 0) begin
              e = rd_exp_q[i].pop_front();
              chk($sformatf("rdata_m%0d", i), m_rdata, e);
            end
          end
        end
        for (int i = 0; i < 2; i++) begin
          if (m_bvalid[i] && m_bready[i]) begin
            ev_log.push_back(20 + i);
            chk($sformatf("b_expected_m%0d", i), wr_exp[i] > 0, 1);
            if (wr_exp[i] > 0) wr_exp[i]--;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int r1_before, r0_before, aw_before, w_before, k;
    repeat (2) @(negedge clk);
    chk("reset_outputs", outs(), 0);
    reset = 1'b0;
    @(negedge clk);

    // simultaneous reads straight out of reset
    ev_log.delete();
    issue_rd(0, 32'h104, 32'hCAFEF00D, 1'b1);
    issue_rd(1, 32'h300, 32'h0BADF00D, 1'b1);
    wait_idle("tie", 200);
`ifdef AXIL_ARB_RR_EN
    chk_str("tie_order", log_str(), "40,10,40,11");
`else
    chk_str("tie_order", log_str(), "40,11,40,10");
`endif

    // single M0 read, registered grant
    ev_log.delete();
    r0_before = r_cnt[0]; r1_before = r_cnt[1];
    issue_rd(0, 32'h100, 32'hDEADBEEF, 1'b1);
    check_ar_grant("m0_read", 0, 32'h100);
    wait_idle("m0_read", 200);
    chk_str("m0_read_order", log_str(), "40,10");
    chk("m0_read_r_cnt_m0", r_cnt[0] - r0_before, 1);
    chk("m0_read_r_cnt_m1", r_cnt[1] - r1_before, 0);

    // M1 write with W accepted two cycles ahead of AW
    ev_log.delete();
    aw_before = s_aw_n; w_before = s_w_n;
    issue_wr(1, 32'h200, 32'h12345678, 4'hF, 2);
    wait_idle("w_early", 200);
    chk_str("w_early_order", log_str(), "31,30,21");
    chk("w_early_aw_count", s_aw_n - aw_before, 1);
    chk("w_early_w_count", s_w_n - w_before, 1);
    chk("w_early_awaddr", cap_awaddr, 32'h200);
    chk("w_early_wdata", cap_wdata, 32'h12345678);
    chk("w_early_wstrb", cap_wstrb, 4'hF);

    // M1 read and write together: read first, then write
    ev_log.delete();
    issue_rd(1, 32'h104, 32'hCAFEF00D, 1'b1);
    issue_wr(1, 32'h204, 32'hA5A5A5A5, 4'h3, 0);
    wait_idle("rd_before_wr", 200);
    chk_str("rd_before_wr_order", log_str(), "40,11,30,31,21");
    chk("rd_before_wr_awaddr", cap_awaddr, 32'h204);
    chk("rd_before_wr_wstrb", cap_wstrb, 4'h3);

    // reset while waiting for read data
    s_rdelay = 6;
    issue_rd(0, 32'h100, 32'h0, 1'b0);
    k = 0;
    while (!s_rready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("rst_reached_rd_data", s_rready, 1);
    reset = 1'b1;
    #1;
    chk("rst_outputs_zero", outs(), 0);
    issue_rd(1, 32'h300, 32'h0BADF00D, 1'b1);
    repeat (2) @(negedge clk);
    chk("rst_held_outputs_zero", outs(), 0);
    s_rdelay = 0;
    reset = 1'b0;
    check_ar_grant("after_rst", 1, 32'h300);
    wait_idle("after_rst", 200);

    // random traffic against a random-timing slave
    rnd_mode = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        logic [31:0] a;
        case ($urandom % 4)
          0: a = 32'h100;
          1: a = 32'h104;
          2: a = 32'h300;
          default: a = $urandom & 32'hFFFF_FFFC;
        endcase
        if (rd_cmd_q[i].size() == 0 && $urandom % 4 == 0)
          issue_rd(i, a, slv_rdata(a), 1'b1);
        if (wr_cmd_q[i].size() == 0 && $urandom % 4 == 0)
          issue_wr(i, a, $urandom, 4'($urandom), int'($urandom % 3));
      end
    end
    wait_idle("random", 3000);
    rnd_mode = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
